// File: rtl/pixy_reset_pkg.sv
// Shared types for the board reset sequencer.
// State encoding, reset-cause codes and counter sizing.
package pixy_reset_pkg;

   typedef enum logic [1:0] {
      ST_HOLD  = 2'd0,
      ST_STAGE = 2'd1,
      ST_RUN   = 2'd2
   } seq_state_e;

   localparam logic [1:0] CAUSE_POR = 2'b01;
   localparam logic [1:0] CAUSE_BTN = 2'b10;

   // One spare bit above the largest interval so the counter cannot wrap.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/reset_debounce.sv
// Push-button path: 2-flop synchroniser and debounce filter.
// rise_o flags the edge on which the debounced level goes high.
module reset_debounce
   import pixy_reset_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1024
) (
   input  logic CPUCLK_IN,
   input  logic RESET_IN,
   input  logic req_i,
   output logic level_o,
   output logic rise_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          meta_q;
   logic          sync_q;
   logic          level_q;
   logic          level_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          differ;
   logic          flip;

   always_comb begin
      differ  = (sync_q != level_q);
      flip    = differ && (cnt_q == LAST);
      level_d = flip ? sync_q : level_q;
      cnt_d   = '0;
      if (differ && !flip) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign level_o = level_q;
   assign rise_o  = flip && !level_q;

   always_ff @(posedge CPUCLK_IN or posedge RESET_IN) begin
      if (RESET_IN) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         meta_q  <= req_i;
         sync_q  <= meta_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/reset_sequencer.sv
// 68000 board reset sequencer: timed peripheral release, CPU last,
// with debounced push-button restart and reset-cause register.
module reset_sequencer
   import pixy_reset_pkg::*;
#(
   parameter int HOLD_CYCLES     = 50000,
   parameter int STAGE_GAP       = 16,
   parameter int NUM_STAGES      = 2,
   parameter int DEBOUNCE_CYCLES = 1024
) (
   input  logic                  CPUCLK_IN,
   input  logic                  RESET_IN,
   input  logic                  REQ_IN,
   output logic                  RESET,
   output logic                  HALT,
   output logic                  RUN,
   output logic [NUM_STAGES-1:0] PERIPH_RESET,
   output logic [1:0]            RESET_CAUSE
);

   localparam int CW = cnt_width(HOLD_CYCLES,
                                 NUM_STAGES * STAGE_GAP,
                                 DEBOUNCE_CYCLES);
   localparam int SW = $clog2(NUM_STAGES + 1);

   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
   localparam logic [SW-1:0] STG_END   = SW'(NUM_STAGES);
   localparam logic [NUM_STAGES-1:0] ONE = NUM_STAGES'(1);

   seq_state_e            state_q;
   logic [CW-1:0]         cnt_q;
   logic [SW-1:0]         stg_q;
   logic                  reset_q;
   logic                  halt_q;
   logic                  run_q;
   logic [NUM_STAGES-1:0] periph_q;
   logic [1:0]            cause_q;

   logic btn_level;
   logic btn_rise;

   reset_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .CPUCLK_IN(CPUCLK_IN),
      .RESET_IN (RESET_IN),
      .req_i    (REQ_IN),
      .level_o  (btn_level),
      .rise_o   (btn_rise)
   );

   always_ff @(posedge CPUCLK_IN or posedge RESET_IN) begin
      if (RESET_IN) begin
         state_q  <= ST_HOLD;
         cnt_q    <= '0;
         stg_q    <= '0;
         reset_q  <= 1'b1;
         halt_q   <= 1'b1;
         run_q    <= 1'b0;
         periph_q <= '1;
         cause_q  <= CAUSE_POR;
      end else if (btn_rise) begin
         state_q  <= ST_HOLD;
         cnt_q    <= '0;
         stg_q    <= '0;
         reset_q  <= 1'b1;
         halt_q   <= 1'b1;
         run_q    <= 1'b0;
         periph_q <= '1;
         cause_q  <= CAUSE_BTN;
      end else if (btn_level) begin
         // Button still held: park at the start of the hold window.
         state_q <= ST_HOLD;
         cnt_q   <= '0;
         stg_q   <= '0;
      end else begin
         unique case (state_q)
            ST_HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  periph_q[0] <= 1'b0;
                  state_q     <= ST_STAGE;
                  cnt_q       <= '0;
                  stg_q       <= SW'(1);
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_STAGE: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_q <= '0;
                  if (stg_q == STG_END) begin
                     reset_q <= 1'b0;
                     halt_q  <= 1'b0;
                     run_q   <= 1'b1;
                     state_q <= ST_RUN;
                  end else begin
                     periph_q <= periph_q & ~(ONE << stg_q);
                     stg_q    <= stg_q + 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_RUN: begin
               state_q <= ST_RUN;
            end
            default: begin
               state_q <= ST_HOLD;
            end
         endcase
      end
   end

   assign RESET        = reset_q;
   assign HALT         = halt_q;
   assign RUN          = run_q;
   assign PERIPH_RESET = periph_q;
   assign RESET_CAUSE  = cause_q;

endmodule
